// File: rtl/mul_if.sv
// rtl/mul_if.sv - Request/result handshake bundle between the execute stage and the multiplier
interface mul_if;
    logic        op_stall;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op_out;

    modport master (
        output op_stall, op_valid, op, op1, op2,
        input  op_ready, op_out
    );

    modport slave (
        input  op_stall, op_valid, op, op1, op2,
        output op_ready, op_out
    );
endinterface

// File: rtl/mul.sv
// rtl/mul.sv - Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-2 shift-add on magnitudes
module mul #(
    parameter int ITERS = 32
) (
    input  logic clk,
    input  logic rstn,
    mul_if.slave bus
);
    localparam int          CW       = $clog2(ITERS + 1);
    localparam logic [1:0]  S_IDLE   = 2'b00;
    localparam logic [1:0]  S_BUSY   = 2'b01;
    localparam logic [1:0]  S_DONE   = 2'b10;
    localparam logic [2:0]  F_MUL    = 3'b000;
    localparam logic [2:0]  F_MULH   = 3'b001;
    localparam logic [2:0]  F_MULHSU = 3'b010;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   prod_q, prod_d;
    logic [31:0]   mcand_q, mcand_d;
    logic          neg_q, neg_d;
    logic [2:0]    sel_q, sel_d;

    logic          sign1, sign2;
    logic [31:0]   abs1, abs2;
    logic [32:0]   sum;
    logic [63:0]   res;

    // Only operands that are signed for the requested op contribute a sign
    assign sign1 = bus.op1[31] & ((bus.op == F_MULH) | (bus.op == F_MULHSU));
    assign sign2 = bus.op2[31] & (bus.op == F_MULH);
    assign abs1  = sign1 ? (32'd0 - bus.op1) : bus.op1;
    assign abs2  = sign2 ? (32'd0 - bus.op2) : bus.op2;

    assign sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign res = neg_q ? (~prod_q + 64'd1) : prod_q;

    assign bus.op_ready = (state_q == S_DONE) && !bus.op_stall;
    assign bus.op_out   = (state_q != S_DONE) ? 32'd0 :
                          (sel_q == F_MUL)    ? res[31:0] : res[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.op_stall) begin
                    state_d = S_BUSY;
                    sel_d   = bus.op;
                    mcand_d = abs1;
                    prod_d  = {32'd0, abs2};
                    neg_d   = sign1 ^ sign2;
                    cnt_d   = CW'(ITERS);
                end
            end
            S_BUSY: begin
                if (!bus.op_stall) begin
                    // Carry of the add lands in bit 63 after the shift
                    prod_d = {sum, prod_q[31:1]};
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.op_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            sel_q   <= sel_d;
        end
    end
endmodule

// File: tb/tb_mul.sv
// tb/tb_mul.sv - Directed self-checking bench for the sequential multiplier
module tb_mul;
    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    mul_if bus ();

    mul #(.ITERS(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request from IDLE; returns cycles to op_ready, result, and count of nonzero op_out while waiting
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int stray);
        bus.op       = o;
        bus.op1      = a;
        bus.op2      = b;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op       = 3'($urandom_range(3, 0));
        bus.op1      = $urandom;
        bus.op2      = $urandom;
        lat   = 0;
        res   = '0;
        stray = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.op_ready) begin
                res = bus.op_out;
                break;
            end
            if (bus.op_out !== 32'd0) stray++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_stall = 1'b0;
        bus.op       = 3'b000;
        bus.op1      = 32'd7;
        bus.op2      = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.op_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.op_ready);
        end
        checks++;
        if (bus.op_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: got %h want 00000000", bus.op_out);
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        rstn         = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int          lat, stray;
        logic [31:0] res;
        run_op(3'b000, 32'd7, 32'd6, lat, res, stray);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 33", lat);
        end
        checks++;
        if (res !== 32'h0000002A) begin
            errors++;
            $display("FAIL basic_result: got %h want 0000002a", res);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL basic_out_idle: got %0d nonzero cycles want 0", stray);
        end
        @(negedge clk);
        checks++;
        if (bus.op_ready !== 1'b0 || bus.op_out !== 32'd0) begin
            errors++;
            $display("FAIL basic_after: got ready=%b out=%h want ready=0 out=00000000",
                     bus.op_ready, bus.op_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_signs();
        logic [2:0]  ops [8] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b001, 3'b000, 3'b011, 3'b010};
        logic [31:0] as  [8] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [8] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd5, 32'd5, 32'h80000000, 32'd2};
        logic [31:0] exs [8] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h40000000, 32'hFFFFFFFF};
        int          lat, stray;
        logic [31:0] res;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, stray);
            checks++;
            if (res !== exs[i] || lat !== 33) begin
                errors++;
                $display("FAIL signs_%0d: got %h lat %0d want %h lat 33", i, res, lat, exs[i]);
            end
        end
    endtask

    task automatic test_stall_idle();
        int          lat, stray;
        logic [31:0] res;
        bus.op       = 3'b011;
        bus.op1      = 32'h80000000;
        bus.op2      = 32'h80000000;
        bus.op_valid = 1'b1;
        bus.op_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.op_stall = 1'b0;
        run_op(3'b011, 32'h80000000, 32'h80000000, lat, res, stray);
        checks++;
        if (lat !== 33 || res !== 32'h40000000) begin
            errors++;
            $display("FAIL stall_idle: got %h lat %0d want 40000000 lat 33", res, lat);
        end
    endtask

    task automatic test_stalls();
        int          ready_cyc = 0;
        logic [31:0] res = '0;
        bus.op       = 3'b001;
        bus.op1      = 32'hFFFFFFFD;
        bus.op2      = 32'd5;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            bus.op_stall = ((c >= 5) && (c <= 9)) || ((c >= 38) && (c <= 40));
            @(negedge clk);
            if (bus.op_ready) begin
                ready_cyc = c;
                res       = bus.op_out;
                break;
            end
            if (c >= 38) begin
                checks++;
                if (bus.op_out !== 32'hFFFFFFFF) begin
                    errors++;
                    $display("FAIL stall_done_hold_c%0d: got %h want ffffffff", c, bus.op_out);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ready_cyc !== 41) begin
            errors++;
            $display("FAIL stall_latency: got %0d want 41", ready_cyc);
        end
        checks++;
        if (res !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL stall_result: got %h want ffffffff", res);
        end
        @(posedge clk); #1;
        bus.op_stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          first = 0, second = 0;
        logic [31:0] r1 = '0, r2 = '0;
        bus.op       = 3'b011;
        bus.op1      = 32'hFFFFFFFF;
        bus.op2      = 32'hFFFFFFFF;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 120; c++) begin
            if (c < 34) begin
                bus.op  = 3'($urandom_range(3, 0));
                bus.op1 = $urandom;
                bus.op2 = $urandom;
            end else begin
                bus.op  = 3'b000;
                bus.op1 = 32'h12345678;
                bus.op2 = 32'h00000010;
            end
            @(negedge clk);
            if (bus.op_ready) begin
                if (first == 0) begin
                    first = c;
                    r1    = bus.op_out;
                end else begin
                    second = c;
                    r2     = bus.op_out;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        checks++;
        if (first !== 33 || r1 !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL b2b_first: got %h at %0d want fffffffe at 33", r1, first);
        end
        checks++;
        if (second !== 67) begin
            errors++;
            $display("FAIL b2b_interval: got %0d want 67", second);
        end
        checks++;
        if (r2 !== 32'h23456780) begin
            errors++;
            $display("FAIL b2b_second: got %h want 23456780", r2);
        end
    endtask

    task automatic test_reset_abort();
        int          lat, stray;
        logic [31:0] res;
        bus.op       = 3'b000;
        bus.op1      = 32'd7;
        bus.op2      = 32'd6;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.op_ready !== 1'b0 || bus.op_out !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs: got ready=%b out=%h want 0 and 00000000",
                     bus.op_ready, bus.op_out);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        run_op(3'b000, 32'd3, 32'd3, lat, res, stray);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL abort_next_latency: got %0d want 33", lat);
        end
        checks++;
        if (res !== 32'd9) begin
            errors++;
            $display("FAIL abort_next_result: got %h want 00000009", res);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_next_idle_out: got %0d nonzero cycles want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_stall_idle();
        test_stalls();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
